// File: rtl/robot_vacuum_multi_scheduler.sv
// Multi-slot daily cleaning scheduler for the robot vacuum.
// Holds NUM_SLOTS programmable start times with per-slot run durations, requests a clean on a
// matching minute boundary and follows the run through the ack/done handshake with timed auto-stop.
// Optional feature macro: RVS_ACK_TIMEOUT_EN (abandon an unacknowledged start after ACK_TIMEOUT
// min_ticks and count it as a missed run).
module robot_vacuum_multi_scheduler #(
  parameter int NUM_SLOTS   = 4,
  parameter int DUR_W       = 8,
  parameter int MISS_W      = 4,
  parameter int ACK_TIMEOUT = 2,
  localparam int SW         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        hour,
  input  logic [5:0]        minute,
  input  logic              min_tick,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [SW-1:0]     cfg_slot,
  input  logic [4:0]        cfg_hour,
  input  logic [5:0]        cfg_minute,
  input  logic [DUR_W-1:0]  cfg_duration,
  input  logic              cfg_valid,
  input  logic              robot_ack,
  input  logic              robot_done,
  output logic              start_cleaning,
  output logic              stop_cleaning,
  output logic              busy,
  output logic [SW-1:0]     active_slot,
  output logic [MISS_W-1:0] missed_count
);

  if (NUM_SLOTS < 1 || ACK_TIMEOUT < 1) begin : g_bad_param
    $error("robot_vacuum_multi_scheduler: NUM_SLOTS and ACK_TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, RUN, STOP} state_t;

  state_t               state, state_nxt;
  logic [4:0]           slot_hour  [NUM_SLOTS];
  logic [5:0]           slot_min   [NUM_SLOTS];
  logic [DUR_W-1:0]     slot_dur   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [DUR_W-1:0]     remaining, remaining_nxt;
  logic [SW-1:0]        active_nxt;
  logic [MISS_W-1:0]    missed_nxt;
  logic                 hit;
  logic [SW-1:0]        hit_idx;
  logic                 timeout;

`ifdef RVS_ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // Count min_ticks spent waiting for robot_ack; cleared whenever not in REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tmo_cnt <= '0;
    else if (state != REQ)   tmo_cnt <= '0;
    else if (min_tick)       tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

  // Slot table: reset restores the default 10:00/60-minute slot 0; out-of-range writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slot_hour[i] <= (i == 0) ? 5'd10 : '0;
        slot_min[i]  <= '0;
        slot_dur[i]  <= (i == 0) ? DUR_W'(60) : '0;
      end
      slot_valid <= NUM_SLOTS'(1);
    end else if (cfg_we && (32'(cfg_slot) < NUM_SLOTS)) begin
      slot_hour[cfg_slot]  <= cfg_hour;
      slot_min[cfg_slot]   <= cfg_minute;
      slot_dur[cfg_slot]   <= cfg_duration;
      slot_valid[cfg_slot] <= cfg_valid;
    end
  end

  // Lowest-index enabled slot matching the current minute, qualified by min_tick and enable.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!hit && min_tick && enable && slot_valid[i] &&
          hour == slot_hour[i] && minute == slot_min[i]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  // Next-state, run-length countdown and missed-run accounting.
  // A zero duration latches remaining=0, which is never decremented, so only robot_done ends it.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    active_nxt    = active_slot;
    timeout       = 1'b0;
    case (state)
      IDLE: if (hit) begin
        state_nxt     = REQ;
        active_nxt    = hit_idx;
        remaining_nxt = slot_dur[hit_idx];
      end
      REQ: begin
        if (robot_ack)   state_nxt = RUN;
        else if (!enable) state_nxt = IDLE;
`ifdef RVS_ACK_TIMEOUT_EN
        else if (min_tick && tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
          state_nxt = IDLE;
          timeout   = 1'b1;
        end
`endif
      end
      RUN: begin
        if (robot_done)    state_nxt = IDLE;
        else if (!enable)  state_nxt = STOP;
        else if (min_tick && remaining != '0) begin
          remaining_nxt = remaining - 1'b1;
          if (remaining == DUR_W'(1)) state_nxt = STOP;
        end
      end
      STOP: if (robot_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    missed_nxt = missed_count;
    if (hit && state != IDLE && missed_nxt != '1) missed_nxt = missed_nxt + 1'b1;
    if (timeout && missed_nxt != '1)               missed_nxt = missed_nxt + 1'b1;
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      remaining      <= '0;
      active_slot    <= '0;
      missed_count   <= '0;
      start_cleaning <= 1'b0;
      stop_cleaning  <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      remaining      <= remaining_nxt;
      active_slot    <= active_nxt;
      missed_count   <= missed_nxt;
      start_cleaning <= (state_nxt == REQ);
      stop_cleaning  <= (state_nxt == STOP);
      busy           <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_robot_vacuum_multi_scheduler.sv
// Directed bench for robot_vacuum_multi_scheduler with hand-computed expectations.
// Honours RVS_ACK_TIMEOUT_EN when the bench is built with it.
module tb_robot_vacuum_multi_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] hour;
  logic [5:0] minute;
  logic       min_tick, enable, cfg_we;
  logic [1:0] cfg_slot;
  logic [4:0] cfg_hour;
  logic [5:0] cfg_minute;
  logic [7:0] cfg_duration;
  logic       cfg_valid, robot_ack, robot_done;
  logic       start_cleaning, stop_cleaning, busy;
  logic [1:0] active_slot;
  logic [3:0] missed_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_miss;

  robot_vacuum_multi_scheduler #(
    .NUM_SLOTS(4), .DUR_W(8), .MISS_W(4), .ACK_TIMEOUT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hour(hour), .minute(minute), .min_tick(min_tick),
    .enable(enable), .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_hour(cfg_hour),
    .cfg_minute(cfg_minute), .cfg_duration(cfg_duration), .cfg_valid(cfg_valid),
    .robot_ack(robot_ack), .robot_done(robot_done), .start_cleaning(start_cleaning),
    .stop_cleaning(stop_cleaning), .busy(busy), .active_slot(active_slot),
    .missed_count(missed_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int h, input int m, input int n);
    hour   = 5'(h);
    minute = 6'(m);
    repeat (n) begin
      min_tick = 1'b1;
      step();
      min_tick = 1'b0;
    end
  endtask

  task automatic cfg(input int s, input int h, input int m, input int d, input int v);
    cfg_we       = 1'b1;
    cfg_slot     = 2'(s);
    cfg_hour     = 5'(h);
    cfg_minute   = 6'(m);
    cfg_duration = 8'(d);
    cfg_valid    = 1'(v);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic ack();
    robot_ack = 1'b1;
    step();
    robot_ack = 1'b0;
  endtask

  task automatic done();
    robot_done = 1'b1;
    step();
    robot_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; hour = '0; minute = '0; min_tick = 1'b0; enable = 1'b0;
    cfg_we = 1'b0; cfg_slot = '0; cfg_hour = '0; cfg_minute = '0; cfg_duration = '0;
    cfg_valid = 1'b0; robot_ack = 1'b0; robot_done = 1'b0;
    #12;
    check("rst_start", start_cleaning, 0);
    check("rst_stop",  stop_cleaning, 0);
    check("rst_busy",  busy, 0);
    check("rst_slot",  active_slot, 0);
    check("rst_miss",  missed_count, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // T1: default slot 0 at 10:00, 60-minute run
    enable = 1'b1;
    tick(10, 0, 1);
    check("t1_start", start_cleaning, 1);
    check("t1_busy",  busy, 1);
    check("t1_slot",  active_slot, 0);
    ack();
    check("t1_start_drop", start_cleaning, 0);
    check("t1_run_busy",   busy, 1);
    tick(12, 0, 59);
    check("t1_stop_59", stop_cleaning, 0);
    tick(12, 0, 1);
    check("t1_stop_60", stop_cleaning, 1);
    step(); step();
    check("t1_stop_hold", stop_cleaning, 1);
    done();
    check("t1_stop_clr", stop_cleaning, 0);
    check("t1_idle",     busy, 0);
    check("t1_miss",     missed_count, 0);

    // T2: two slots at 07:30, lowest index wins, no miss for the loser
    cfg(2, 7, 30, 3, 1);
    cfg(1, 7, 30, 5, 1);
    tick(7, 30, 1);
    check("t2_slot", active_slot, 1);
    check("t2_miss", missed_count, 0);
    ack();
    tick(8, 0, 4);
    check("t2_stop_4", stop_cleaning, 0);
    tick(8, 0, 1);
    check("t2_stop_5", stop_cleaning, 1);
    done();
    check("t2_idle", busy, 0);

    // robot_done on the same edge that remaining hits 0 -> IDLE without stop
    cfg(1, 7, 30, 5, 0);
    tick(7, 30, 1);
    check("tie_slot", active_slot, 2);
    ack();
    tick(8, 0, 2);
    min_tick = 1'b1; robot_done = 1'b1;
    step();
    min_tick = 1'b0; robot_done = 1'b0;
    check("tie_busy", busy, 0);
    check("tie_stop", stop_cleaning, 0);

    // T3: duration 0 runs until robot_done
    cfg(3, 9, 15, 0, 1);
    tick(9, 15, 1);
    check("t3_slot", active_slot, 3);
    ack();
    tick(12, 0, 100);
    check("t3_stop", stop_cleaning, 0);
    check("t3_busy", busy, 1);
    done();
    check("t3_idle", busy, 0);
    check("t3_miss", missed_count, 0);

    // T6: no ack for two min_ticks
    tick(10, 0, 1);
    check("t6_req", start_cleaning, 1);
    tick(12, 0, 1);
    check("t6_tick1", start_cleaning, 1);
    tick(12, 0, 1);
`ifdef RVS_ACK_TIMEOUT_EN
    check("t6_start", start_cleaning, 0);
    check("t6_busy",  busy, 0);
    exp_miss = 1;
`else
    check("t6_start", start_cleaning, 1);
    check("t6_busy",  busy, 1);
    exp_miss = 0;
`endif
    check("t6_miss", missed_count, 32'(exp_miss));
    enable = 1'b0;
    step();
    enable = 1'b1;
    check("t6_clear", busy, 0);

    // T4: trigger while running is dropped and counted, saturating
    cfg(3, 10, 1, 0, 1);
    tick(10, 0, 1);
    ack();
    tick(10, 1, 1);
    check("t4_miss1", missed_count, 32'(exp_miss + 1));
    check("t4_busy",  busy, 1);
    check("t4_slot",  active_slot, 0);
    tick(10, 1, 15);
    check("t4_sat",  missed_count, 15);
    check("t4_stop", stop_cleaning, 0);

    // T5: enable=0 in RUN -> STOP until robot_done
    enable = 1'b0;
    step();
    check("t5_run_stop", stop_cleaning, 1);
    step();
    check("t5_run_hold", stop_cleaning, 1);
    done();
    check("t5_run_idle", busy, 0);
    enable = 1'b1;

    // T5: enable=0 in REQ -> IDLE
    tick(10, 0, 1);
    check("t5_req", start_cleaning, 1);
    enable = 1'b0;
    step();
    check("t5_req_start", start_cleaning, 0);
    check("t5_req_busy",  busy, 0);
    enable = 1'b1;

    // Asynchronous reset mid-run restores outputs and slot table
    tick(10, 0, 1);
    ack();
    #3 rst_n = 1'b0;
    #1;
    check("ar_busy",  busy, 0);
    check("ar_start", start_cleaning, 0);
    check("ar_miss",  missed_count, 0);
    @(negedge clk) rst_n = 1'b1;
    tick(10, 1, 1);
    check("ar_slot3_gone", busy, 0);
    tick(10, 0, 1);
    check("ar_slot0", start_cleaning, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
